// File: rtl/conv_pe_p_pkg.sv
// Shared constants, derived sizes and fixed-point helpers for the convolution PE.
// Helpers work on a wide signed type so that any parameterisation up to 64-bit words fits.
package conv_pe_p_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FRAC_BITS  = 16;
    localparam int DEF_KNL_DIM    = 5;
    localparam int DEF_KNL_MAXNUM = 16;
    localparam int DEF_SATURATE   = 1;

    localparam int WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int win_size(input int knl_dim);
        return knl_dim * knl_dim;
    endfunction

    function automatic int bank_size(input int knl_dim, input int knl_maxnum);
        return knl_maxnum * knl_dim * knl_dim;
    endfunction

    function automatic int sum_width(input int data_width, input int num_terms);
        return data_width + $clog2(num_terms) + 1;
    endfunction

    // Optional half-up bias followed by an arithmetic shift back to word scale.
    function automatic wide_t round_shift(input wide_t prod, input logic rnd, input int frac);
        wide_t bias;
        if (rnd) begin
            bias = 128'sd1 <<< (frac - 1);
        end else begin
            bias = 128'sd0;
        end
        return (prod + bias) >>> frac;
    endfunction

    // Clamp to the signed range of a dw-bit word.
    function automatic wide_t sat_clamp(input wide_t v, input int dw);
        wide_t max_v;
        wide_t min_v;
        max_v = (128'sd1 <<< (dw - 1)) - 128'sd1;
        min_v = -(128'sd1 <<< (dw - 1));
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/conv_pe_tree.sv
// Final-stage reduction: pairwise adder tree over the products plus the upstream
// partial sum, followed by optional clamping to the output word width.
module conv_pe_tree
    import conv_pe_p_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_TERMS  = DEF_KNL_DIM * DEF_KNL_DIM,
    parameter int SATURATE   = DEF_SATURATE
) (
    input  logic [NUM_TERMS-1:0][DATA_WIDTH-1:0] terms,
    input  logic [DATA_WIDTH-1:0]                acc,
    input  logic                                 use_acc,
    output logic [DATA_WIDTH-1:0]                result
);

    localparam int SUM_W  = sum_width(DATA_WIDTH, NUM_TERMS);
    localparam int LEAVES = NUM_TERMS + 1;
    localparam int PAD    = 1 << $clog2(LEAVES);

    // Heap layout: node n has children 2n+1 and 2n+2, leaves start at PAD-1.
    logic signed [SUM_W-1:0] node_s [2*PAD-1];

    // Populate leaves (sign-extended) and reduce level by level toward the root
    always_comb begin
        for (int n = 0; n < 2 * PAD - 1; n++) begin
            node_s[n] = '0;
        end
        for (int i = 0; i < NUM_TERMS; i++) begin
            node_s[PAD-1+i] = SUM_W'(signed'(terms[i]));
        end
        if (use_acc) begin
            node_s[PAD-1+NUM_TERMS] = SUM_W'(signed'(acc));
        end else begin
            node_s[PAD-1+NUM_TERMS] = '0;
        end
        for (int n = PAD - 2; n >= 0; n--) begin
            node_s[n] = node_s[2*n+1] + node_s[2*n+2];
        end
    end

    // Clamp or wrap the root sum to the output word
    always_comb begin
        if (SATURATE != 0) begin
            result = DATA_WIDTH'(sat_clamp(wide_t'(node_s[0]), DATA_WIDTH));
        end else begin
            result = DATA_WIDTH'(node_s[0]);
        end
    end

endmodule

// File: rtl/conv_pe_p.sv
// Convolution processing element: shift-loaded kernel bank and input window feeding
// a three-stage fixed-point MAC pipeline (capture, multiply, reduce).
module conv_pe_p
    import conv_pe_p_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int KNL_DIM    = DEF_KNL_DIM,
    parameter int KNL_MAXNUM = DEF_KNL_MAXNUM,
    parameter int SATURATE   = DEF_SATURATE
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          ld_knl,
    input  logic                          ld_ifmap,
    input  logic                          start,
    input  logic [$clog2(KNL_MAXNUM):0]   num_knls,
    input  logic [$clog2(KNL_MAXNUM)-1:0] knl_sel,
    input  logic [DATA_WIDTH-1:0]         acc_in,
    input  logic                          disable_acc,
    input  logic                          round_mode,
    output logic                          knl_full,
    output logic                          win_full,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         data_out
);

    localparam int WIN_N  = win_size(KNL_DIM);
    localparam int BANK_N = bank_size(KNL_DIM, KNL_MAXNUM);
    localparam int SEL_W  = $clog2(KNL_MAXNUM);
    localparam int SLOT_W = SEL_W + 2;
    localparam int BIDX_W = $clog2(BANK_N);
    localparam int KCNT_W = $clog2(BANK_N + 1);
    localparam int WCNT_W = $clog2(WIN_N + 1);

    logic [DATA_WIDTH-1:0] bank_r [BANK_N];
    logic [DATA_WIDTH-1:0] win_r  [WIN_N];
    logic [KCNT_W-1:0]     knl_cnt_r;
    logic [WCNT_W-1:0]     win_cnt_r;
    logic                  knl_full_r;
    logic                  win_full_r;

    logic [SLOT_W-1:0]     slot_sum_s;
    logic [SEL_W-1:0]      slot_s;
    logic [DATA_WIDTH-1:0] knl_pick_s [WIN_N];
    logic                  accept_s;

    logic signed [DATA_WIDTH-1:0] knl_s1_r [WIN_N];
    logic signed [DATA_WIDTH-1:0] win_s1_r [WIN_N];
    logic [DATA_WIDTH-1:0]        acc_s1_r;
    logic                         use_acc_s1_r;
    logic                         rnd_s1_r;
    logic                         valid_s1_r;

    logic [WIN_N-1:0][DATA_WIDTH-1:0] prod_s2_r;
    logic [DATA_WIDTH-1:0]            acc_s2_r;
    logic                             use_acc_s2_r;
    logic                             valid_s2_r;

    logic [DATA_WIDTH-1:0] tree_sum_s;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] data_out_r;

    // Kernel bank shift register; shifting continues once full, only the count stops
    always_ff @(posedge clk) begin
        if (!srstn) begin
            for (int i = 0; i < BANK_N; i++) begin
                bank_r[i] <= '0;
            end
            knl_cnt_r  <= '0;
            knl_full_r <= 1'b0;
        end else if (ld_knl) begin
            for (int i = 0; i < BANK_N - 1; i++) begin
                bank_r[i] <= bank_r[i+1];
            end
            bank_r[BANK_N-1] <= data_in;
            if (knl_cnt_r != KCNT_W'(BANK_N)) begin
                knl_cnt_r  <= knl_cnt_r + KCNT_W'(1'b1);
                knl_full_r <= (knl_cnt_r == KCNT_W'(BANK_N - 1));
            end
        end
    end

    // Input window shift register with saturating fill count
    always_ff @(posedge clk) begin
        if (!srstn) begin
            for (int i = 0; i < WIN_N; i++) begin
                win_r[i] <= '0;
            end
            win_cnt_r  <= '0;
            win_full_r <= 1'b0;
        end else if (ld_ifmap) begin
            for (int i = 0; i < WIN_N - 1; i++) begin
                win_r[i] <= win_r[i+1];
            end
            win_r[WIN_N-1] <= data_in;
            if (win_cnt_r != WCNT_W'(WIN_N)) begin
                win_cnt_r  <= win_cnt_r + WCNT_W'(1'b1);
                win_full_r <= (win_cnt_r == WCNT_W'(WIN_N - 1));
            end
        end
    end

    // Kernels are loaded oldest-first, so the most recent num_knls occupy the top slots.
    assign slot_sum_s = SLOT_W'(2 * KNL_MAXNUM) + SLOT_W'(knl_sel) - SLOT_W'(num_knls);
    assign slot_s     = SEL_W'(slot_sum_s % SLOT_W'(KNL_MAXNUM));
    assign accept_s   = start & win_full_r;

    // Route the effective kernel slot toward the stage-1 capture registers
    always_comb begin
        for (int i = 0; i < WIN_N; i++) begin
            knl_pick_s[i] = bank_r[BIDX_W'(slot_s) * BIDX_W'(WIN_N) + BIDX_W'(i)];
        end
    end

    // Stage 1: snapshot kernel, window (pre-shift value) and per-MAC controls
    always_ff @(posedge clk) begin
        if (!srstn) begin
            for (int i = 0; i < WIN_N; i++) begin
                knl_s1_r[i] <= '0;
                win_s1_r[i] <= '0;
            end
            acc_s1_r     <= '0;
            use_acc_s1_r <= 1'b0;
            rnd_s1_r     <= 1'b0;
            valid_s1_r   <= 1'b0;
        end else begin
            valid_s1_r <= accept_s;
            if (accept_s) begin
                for (int i = 0; i < WIN_N; i++) begin
                    knl_s1_r[i] <= knl_pick_s[i];
                    win_s1_r[i] <= win_r[i];
                end
                acc_s1_r     <= acc_in;
                use_acc_s1_r <= ~disable_acc;
                rnd_s1_r     <= round_mode;
            end
        end
    end

    // Stage 2: kernel times transposed window, rescaled and truncated to word width
    always_ff @(posedge clk) begin
        if (!srstn) begin
            prod_s2_r    <= '0;
            acc_s2_r     <= '0;
            use_acc_s2_r <= 1'b0;
            valid_s2_r   <= 1'b0;
        end else begin
            valid_s2_r <= valid_s1_r;
            if (valid_s1_r) begin
                for (int i = 0; i < KNL_DIM; i++) begin
                    for (int j = 0; j < KNL_DIM; j++) begin
                        prod_s2_r[i*KNL_DIM+j] <= DATA_WIDTH'(round_shift(
                            wide_t'(knl_s1_r[i*KNL_DIM+j]) * wide_t'(win_s1_r[j*KNL_DIM+i]),
                            rnd_s1_r, FRAC_BITS));
                    end
                end
                acc_s2_r     <= acc_s1_r;
                use_acc_s2_r <= use_acc_s1_r;
            end
        end
    end

    conv_pe_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TERMS  (WIN_N),
        .SATURATE   (SATURATE)
    ) u_tree (
        .terms   (prod_s2_r),
        .acc     (acc_s2_r),
        .use_acc (use_acc_s2_r),
        .result  (tree_sum_s)
    );

    // Stage 3: register the reduced result; data_out holds between results
    always_ff @(posedge clk) begin
        if (!srstn) begin
            out_valid_r <= 1'b0;
            data_out_r  <= '0;
        end else begin
            out_valid_r <= valid_s2_r;
            if (valid_s2_r) begin
                data_out_r <= tree_sum_s;
            end
        end
    end

    assign knl_full  = knl_full_r;
    assign win_full  = win_full_r;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;

endmodule

// File: tb/tb_conv_pe_p.sv
// Directed bench for conv_pe_p: a saturating and a wrapping instance share one stimulus
// stream; expected values are hand-computed Q16.16 results.
module tb_conv_pe_p;

    logic        clk = 1'b0;
    logic        srstn;
    logic [31:0] data_in;
    logic        ld_knl;
    logic        ld_ifmap;
    logic        start;
    logic [4:0]  num_knls;
    logic [3:0]  knl_sel;
    logic [31:0] acc_in;
    logic        disable_acc;
    logic        round_mode;

    logic        knl_full, win_full, out_valid;
    logic [31:0] data_out;
    logic        knl_full_w, win_full_w, out_valid_w;
    logic [31:0] data_out_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_pe_p dut (
        .clk(clk), .srstn(srstn), .data_in(data_in), .ld_knl(ld_knl), .ld_ifmap(ld_ifmap),
        .start(start), .num_knls(num_knls), .knl_sel(knl_sel), .acc_in(acc_in),
        .disable_acc(disable_acc), .round_mode(round_mode), .knl_full(knl_full),
        .win_full(win_full), .out_valid(out_valid), .data_out(data_out)
    );

    conv_pe_p #(.SATURATE(0)) dut_wrap (
        .clk(clk), .srstn(srstn), .data_in(data_in), .ld_knl(ld_knl), .ld_ifmap(ld_ifmap),
        .start(start), .num_knls(num_knls), .knl_sel(knl_sel), .acc_in(acc_in),
        .disable_acc(disable_acc), .round_mode(round_mode), .knl_full(knl_full_w),
        .win_full(win_full_w), .out_valid(out_valid_w), .data_out(data_out_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push_knl(input logic [31:0] w);
        data_in = w;
        ld_knl  = 1'b1;
        tick();
        ld_knl  = 1'b0;
    endtask

    task automatic push_win(input logic [31:0] w);
        data_in  = w;
        ld_ifmap = 1'b1;
        tick();
        ld_ifmap = 1'b0;
    endtask

    task automatic launch(input logic rnd, input logic dis, input logic [31:0] acc);
        round_mode  = rnd;
        disable_acc = dis;
        acc_in      = acc;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Called right after launch(): one edge later still idle, two edges later valid.
    task automatic expect_result(input string tag, input logic [31:0] exp_v);
        tick();
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, data_out, exp_v);
    endtask

    initial begin
        srstn = 1'b0; data_in = 32'd0; ld_knl = 1'b0; ld_ifmap = 1'b0; start = 1'b0;
        num_knls = 5'd16; knl_sel = 4'd0; acc_in = 32'd0; disable_acc = 1'b1; round_mode = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_knl_full", {31'd0, knl_full}, 32'd0);
        chk("rst_win_full", {31'd0, win_full}, 32'd0);
        srstn = 1'b1;
        tick();

        // start with only 24 window words must be ignored
        for (int k = 0; k < 24; k++) push_win(32'h0002_0000);
        chk("win_not_full", {31'd0, win_full}, 32'd0);
        launch(1'b0, 1'b1, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("short_win_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        push_win(32'h0002_0000);
        chk("win_full", {31'd0, win_full}, 32'd1);

        // fill the whole bank: kernel 0 is unity, all later kernels zero
        for (int k = 0; k < 399; k++) push_knl((k < 25) ? 32'h0001_0000 : 32'd0);
        chk("knl_not_full", {31'd0, knl_full}, 32'd0);
        push_knl(32'd0);
        chk("knl_full", {31'd0, knl_full}, 32'd1);

        // unity: 25 * (1.0 * 2.0) = 50.0; bank shifted while in flight
        num_knls = 5'd16; knl_sel = 4'd0;
        launch(1'b0, 1'b1, 32'd0);
        data_in = 32'hDEAD_BEEF;
        ld_knl  = 1'b1;
        tick();
        ld_knl  = 1'b0;
        chk("unity_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("unity_valid", {31'd0, out_valid}, 32'd1);
        chk("unity_data", data_out, 32'h0032_0000);
        chk("unity_wrap_data", data_out_w, 32'h0032_0000);
        tick();
        chk("unity_one_shot", {31'd0, out_valid}, 32'd0);
        chk("unity_hold", data_out, 32'h0032_0000);

        // transpose + accumulate: knl[1] pairs with win[5]; 1.0*3.0 + 1.0
        for (int k = 0; k < 25; k++) push_knl((k == 1) ? 32'h0001_0000 : 32'd0);
        for (int k = 0; k < 25; k++) push_win((k == 5) ? 32'h0003_0000 : 32'd0);
        num_knls = 5'd1; knl_sel = 4'd0;
        launch(1'b0, 1'b0, 32'h0001_0000);
        expect_result("transpose", 32'h0004_0000);

        // rounding: 0.5 * 2^-16 truncates to 0, rounds up to 1 LSB
        for (int k = 0; k < 25; k++) push_knl((k == 0) ? 32'h0000_8000 : 32'd0);
        for (int k = 0; k < 25; k++) push_win((k == 0) ? 32'h0000_0001 : 32'd0);
        launch(1'b0, 1'b1, 32'd0);
        expect_result("round_trunc", 32'd0);
        launch(1'b1, 1'b1, 32'd0);
        expect_result("round_half_up", 32'd1);
        // same-cycle window shift must not disturb the snapshot
        data_in  = 32'd0;
        ld_ifmap = 1'b1;
        launch(1'b1, 1'b1, 32'd0);
        ld_ifmap = 1'b0;
        expect_result("snapshot", 32'd1);

        // saturation: 25 * 0x7FFF0000 + 0x7FFFFFFF
        for (int k = 0; k < 25; k++) push_knl(32'h7FFF_0000);
        for (int k = 0; k < 25; k++) push_win(32'h0001_0000);
        launch(1'b0, 1'b0, 32'h7FFF_FFFF);
        expect_result("saturate", 32'h7FFF_FFFF);
        chk("wrap_data", data_out_w, 32'hFFE6_FFFF);

        // three back-to-back starts -> three consecutive results
        for (int k = 0; k < 25; k++) push_knl((k == 0) ? 32'h0000_8000 : 32'd0);
        for (int k = 0; k < 25; k++) push_win((k == 0) ? 32'h0000_0001 : 32'd0);
        round_mode = 1'b0; disable_acc = 1'b0; acc_in = 32'd5; start = 1'b1;
        tick();
        round_mode = 1'b1; acc_in = 32'd5;
        tick();
        acc_in = 32'h0000_0010;
        tick();
        start = 1'b0;
        chk("b2b_valid0", {31'd0, out_valid}, 32'd1);
        chk("b2b_data0", data_out, 32'd5);
        tick();
        chk("b2b_valid1", {31'd0, out_valid}, 32'd1);
        chk("b2b_data1", data_out, 32'd6);
        tick();
        chk("b2b_valid2", {31'd0, out_valid}, 32'd1);
        chk("b2b_data2", data_out, 32'h0000_0011);
        tick();
        chk("b2b_end", {31'd0, out_valid}, 32'd0);

        // reset one cycle after start discards the in-flight MAC
        launch(1'b0, 1'b1, 32'd0);
        srstn = 1'b0;
        tick();
        srstn = 1'b1;
        chk("midrst_data", data_out, 32'd0);
        chk("midrst_win_full", {31'd0, win_full}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_pe_p.md
CONV_PE_P -- requirements
Module: conv_pe_p

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, signed fixed-point word width.
REQ-002 SHALL have parameter FRAC_BITS, 16, fractional bits per word.
REQ-003 SHALL have parameter KNL_DIM, 5, kernel side K (window K*K).
REQ-004 SHALL have parameter KNL_MAXNUM, 16, kernel bank depth.
REQ-005 SHALL have parameter SATURATE, 1, 1 = saturate output, 0 = wrap.
REQ-006 SHALL have ports: clk  in  1  clock; srstn  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: data_in  in  DATA_WIDTH  load word; ld_knl  in  1  shift into kernel bank; ld_ifmap  in  1  shift into window.
REQ-008 SHALL have ports: start  in  1  launch one MAC; num_knls  in  clog2(KNL_MAXNUM)+1  kernels loaded; knl_sel  in  clog2(KNL_MAXNUM)  kernel index.
REQ-009 SHALL have ports: acc_in  in  DATA_WIDTH  upstream partial sum; disable_acc  in  1  ignore acc_in; round_mode  in  1  0 truncate, 1 round-half-up.
REQ-010 SHALL have ports: knl_full  out  1; win_full  out  1; out_valid  out  1; data_out  out  DATA_WIDTH.

Function
REQ-011 ld_knl SHALL shift data_in into bank tail (entry KNL_MAXNUM*K*K-1), all entries move one toward index 0.
REQ-012 Kernel word counter SHALL increment per ld_knl, saturate at KNL_MAXNUM*K*K; knl_full = counter at max; shifting continues when full.
REQ-013 ld_ifmap SHALL shift data_in into window tail (entry K*K-1); window counter saturates at K*K; win_full = counter at max.
REQ-014 Effective kernel slot SHALL be (KNL_MAXNUM - num_knls + knl_sel) mod KNL_MAXNUM; slot s occupies entries s*K*K .. s*K*K+K*K-1.
REQ-015 start with win_full=0 SHALL be ignored (no out_valid).
REQ-016 Stage 1 (start cycle edge): register selected kernel, window snapshot, acc_in, disable_acc, round_mode; snapshot SHALL be window value before any same-cycle ld_ifmap.
REQ-017 Stage 2: product p[i*K+j] = knl[i*K+j] * win[j*K+i] (transposed), full 2*DATA_WIDTH signed; round_mode=1 adds 2^(FRAC_BITS-1) before arithmetic shift right FRAC_BITS; result truncated to DATA_WIDTH and registered.
REQ-018 Stage 3: sum of K*K terms plus acc_in (unless disable_acc) in DATA_WIDTH+clog2(K*K)+1 bits; SATURATE=1 clamps to [-2^(DW-1), 2^(DW-1)-1], else low DATA_WIDTH bits; registered to data_out.
REQ-019 Latency SHALL be 3 cycles: start at edge n -> out_valid=1 for one cycle after edge n+3; back-to-back starts SHALL give one result per cycle.
REQ-020 data_out SHALL hold last result when out_valid=0.
REQ-021 ld_knl during an in-flight MAC SHALL not affect it (kernel captured at stage 1).

Reset
REQ-022 srstn=0 SHALL clear kernel bank, window, both counters, all pipeline registers, pipeline valid bits; out_valid=0, data_out=0, knl_full=0, win_full=0.
REQ-023 Reset mid-operation SHALL discard in-flight MACs; no out_valid after release until a new accepted start.

Structure
REQ-024 Shared package SHALL hold default parameter constants, derived widths (window size, bank size, sum width) and the saturate/round helper function.
REQ-025 One sub-module conv_pe_tree SHALL implement stage-3 adder tree plus saturation; remainder flat.

Verification
REQ-026 Unity: load kernel 0 all 0x00010000, window all 0x00020000, num_knls=16, knl_sel=0, disable_acc=1, start -> out_valid 3 cycles later, data_out 0x00320000.
REQ-027 Accumulate/transpose: kernel with single 1.0 at index 1, window index 5 = 3.0, acc_in 0x00010000, disable_acc=0 -> data_out 0x00040000.
REQ-028 Rounding: kernel[0]=0x00008000, window[0]=0x00000001, others 0; round_mode=0 -> 0, round_mode=1 -> 1.
REQ-029 Saturation: all 25 products 0x7FFF0000 (kernel 0x7FFF0000, window 1.0), acc_in 0x7FFFFFFF -> data_out 0x7FFFFFFF; SATURATE=0 build -> wrapped low bits.
REQ-030 Boundaries: start after 24 ld_ifmap -> no out_valid; reset asserted 1 cycle after start -> no out_valid; 3 back-to-back starts -> 3 consecutive out_valid cycles.
